mc_seq: RTL and testbench

Microcode sequencer feeding the 64-word × 27-bit microcode ROM. It generates the 6-bit ROM address `a[0:5]` and decodes the next-address field of each returned microword: increment, jump, conditional branch, call/return, loop and halt. It runs on `sys_clk` and advances once per rising edge of the phase clock `clk`, in lock-step with the ROM's registered output.

---
 rtl/mc_seq_pkg.sv | 37 +++
 rtl/mc_seq_if.sv | 27 ++
 rtl/mc_stack.sv | 55 +++++
 rtl/mc_seq.sv | 160 ++++++++++++++++
 tb/tb_mc_seq.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_seq_pkg.sv
// Shared definitions for the microcode sequencer: op codes, FSM states,
// address width and the bit layout of the sequencer fields in a microword.
package mc_seq_pkg;

    localparam int MC_AW = 6;

    // Sequencer field positions inside the 12 low microword bits z[0:11]
    localparam int MW_W          = 12;
    localparam int FLD_OP_LSB    = 0;
    localparam int FLD_OP_W      = 3;
    localparam int FLD_ADDR_LSB  = 3;
    localparam int FLD_CSEL_LSB  = 9;
    localparam int FLD_CSEL_W    = 2;
    localparam int FLD_CINV_BIT  = 11;

    localparam logic [2:0] SEQ_NEXT   = 3'd0;
    localparam logic [2:0] SEQ_JUMP   = 3'd1;
    localparam logic [2:0] SEQ_BRANCH = 3'd2;
    localparam logic [2:0] SEQ_CALL   = 3'd3;
    localparam logic [2:0] SEQ_RET    = 3'd4;
    localparam logic [2:0] SEQ_HALT   = 3'd5;
    localparam logic [2:0] SEQ_LOOP   = 3'd6;
    localparam logic [2:0] SEQ_LDCNT  = 3'd7;

    localparam logic [MC_AW-1:0] MC_ONE = {{(MC_AW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } seq_state_e;

    function automatic logic [MC_AW-1:0] addr_inc(input logic [MC_AW-1:0] addr);
        return addr + MC_ONE;
    endfunction

endpackage

// File: rtl/mc_seq_if.sv
// Sequencer bus: control handshake, ROM microword fields, condition flags
// and the registered address/status returned by the sequencer.
interface mc_seq_if;
    import mc_seq_pkg::*;

    logic             start;
    logic [MC_AW-1:0] start_addr;
    logic [2:0]       seq_op;
    logic [MC_AW-1:0] seq_addr;
    logic [1:0]       cond_sel;
    logic             cond_inv;
    logic [3:0]       cond;
    logic [MC_AW-1:0] a;
    logic             busy;
    logic             err;

    modport master (
        input  start, start_addr, seq_op, seq_addr, cond_sel, cond_inv, cond,
        output a, busy, err
    );

    modport slave (
        output start, start_addr, seq_op, seq_addr, cond_sel, cond_inv, cond,
        input  a, busy, err
    );

endinterface

// File: rtl/mc_stack.sv
// Return-address LIFO. A push into a full stack discards the oldest entry so
// the most recent return addresses always survive.
module mc_stack
    import mc_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [MC_AW-1:0] push_data,
    output logic [MC_AW-1:0] top_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] SP_ONE = {{PW{1'b0}}, 1'b1};

    logic [PW:0]      sp_r;
    logic [MC_AW-1:0] mem_r [DEPTH];
    logic [PW-1:0]    top_idx_s;

    assign top_idx_s = PW'(sp_r - SP_ONE);
    assign top_data  = mem_r[top_idx_s];
    assign full      = (sp_r == (PW+1)'(DEPTH));
    assign empty     = (sp_r == {(PW+1){1'b0}});

    // Stack pointer and storage; index 0 always holds the oldest entry
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            sp_r <= {(PW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {MC_AW{1'b0}};
            end
        end else if (clear) begin
            sp_r <= {(PW+1){1'b0}};
        end else if (push) begin
            if (full) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    mem_r[i] <= mem_r[i+1];
                end
                mem_r[DEPTH-1] <= push_data;
            end else begin
                mem_r[sp_r[PW-1:0]] <= push_data;
                sp_r                <= sp_r + SP_ONE;
            end
        end else if (pop && !empty) begin
            sp_r <= sp_r - SP_ONE;
        end
    end

endmodule

// File: rtl/mc_seq.sv
// Microcode sequencer: detects phase-clock edges, waits one cycle for the ROM
// word, then computes the next ROM address from the microword's sequencer field.
module mc_seq
    import mc_seq_pkg::*;
#(
    parameter int STACK_DEPTH = 4
) (
    input  logic   sys_clk,
    input  logic   reset,
    input  logic   clk,
    mc_seq_if.master bus
);

    logic             clk_prev_r;
    logic             step_r;
    logic             edge_s;
    seq_state_e       state_r;
    seq_state_e       state_nxt_s;
    logic [MC_AW-1:0] a_r;
    logic [MC_AW-1:0] a_nxt_s;
    logic [MC_AW-1:0] a_inc_s;
    logic [MC_AW-1:0] cnt_r;
    logic [MC_AW-1:0] cnt_nxt_s;
    logic             busy_r;
    logic             err_r;
    logic             err_nxt_s;
    logic             cond_s;
    logic             push_s;
    logic             pop_s;
    logic             clear_s;
    logic [MC_AW-1:0] stk_top_s;
    logic             stk_full_s;
    logic             stk_empty_s;

    assign edge_s  = clk & ~clk_prev_r;
    assign a_inc_s = addr_inc(a_r);
    assign cond_s  = bus.cond[bus.cond_sel] ^ bus.cond_inv;

    assign bus.a    = a_r;
    assign bus.busy = busy_r;
    assign bus.err  = err_r;

    mc_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .clear     (clear_s),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (a_inc_s),
        .top_data  (stk_top_s),
        .full      (stk_full_s),
        .empty     (stk_empty_s)
    );

    // Phase-clock rising-edge detect and one-cycle delay to the ROM-valid step
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            clk_prev_r <= 1'b1;
            step_r     <= 1'b0;
        end else begin
            clk_prev_r <= clk;
            step_r     <= edge_s;
        end
    end

    // Next-state and next-address decode; steps only act in RUN
    always_comb begin
        state_nxt_s = state_r;
        a_nxt_s     = a_r;
        err_nxt_s   = err_r;
        cnt_nxt_s   = cnt_r;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        clear_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    a_nxt_s     = bus.start_addr;
                    err_nxt_s   = 1'b0;
                    clear_s     = 1'b1;
                    state_nxt_s = ST_ARM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (edge_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_ARM;
                end
            end
            ST_RUN: begin
                if (step_r) begin
                    case (bus.seq_op)
                        SEQ_NEXT:   a_nxt_s = a_inc_s;
                        SEQ_JUMP:   a_nxt_s = bus.seq_addr;
                        SEQ_BRANCH: a_nxt_s = cond_s ? bus.seq_addr : a_inc_s;
                        SEQ_CALL: begin
                            push_s  = 1'b1;
                            a_nxt_s = bus.seq_addr;
                            if (stk_full_s) begin
                                err_nxt_s = 1'b1;
                            end else begin
                                err_nxt_s = err_r;
                            end
                        end
                        SEQ_RET: begin
                            if (stk_empty_s) begin
                                a_nxt_s     = {MC_AW{1'b0}};
                                err_nxt_s   = 1'b1;
                                state_nxt_s = ST_IDLE;
                            end else begin
                                pop_s   = 1'b1;
                                a_nxt_s = stk_top_s;
                            end
                        end
                        SEQ_HALT:   state_nxt_s = ST_IDLE;
                        SEQ_LOOP: begin
                            if (cnt_r != {MC_AW{1'b0}}) begin
                                cnt_nxt_s = cnt_r - MC_ONE;
                                a_nxt_s   = bus.seq_addr;
                            end else begin
                                a_nxt_s = a_inc_s;
                            end
                        end
                        SEQ_LDCNT: begin
                            cnt_nxt_s = bus.seq_addr;
                            a_nxt_s   = a_inc_s;
                        end
                        default:    a_nxt_s = a_r;
                    endcase
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Sequencer state and registered outputs
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            a_r     <= {MC_AW{1'b0}};
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
            cnt_r   <= {MC_AW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            a_r     <= a_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            err_r   <= err_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_mc_seq.sv
// Directed bench for mc_seq: a small registered-ROM model feeds microwords
// back to the sequencer while a phase clock of period 4 runs alongside.
module tb_mc_seq;
    import mc_seq_pkg::*;

    logic sys_clk;
    logic reset;
    logic clk;
    mc_seq_if bus();

    mc_seq #(.STACK_DEPTH(4)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .clk     (clk),
        .bus     (bus)
    );

    logic [MW_W-1:0] rom [64];
    logic [MW_W-1:0] rom_q;
    logic            clk_last;
    logic            last_edge;
    int              ph;
    int              nvec;
    int              nerr;

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    function automatic logic [MW_W-1:0] mw(input logic [2:0] op, input logic [MC_AW-1:0] ad,
                                           input logic [1:0] cs, input logic ci);
        logic [MW_W-1:0] w;
        w = {MW_W{1'b0}};
        w[FLD_OP_LSB +: FLD_OP_W]     = op;
        w[FLD_ADDR_LSB +: MC_AW]      = ad;
        w[FLD_CSEL_LSB +: FLD_CSEL_W] = cs;
        w[FLD_CINV_BIT]               = ci;
        return w;
    endfunction

    task automatic drive_rom();
        bus.seq_op   = rom_q[FLD_OP_LSB +: FLD_OP_W];
        bus.seq_addr = rom_q[FLD_ADDR_LSB +: MC_AW];
        bus.cond_sel = rom_q[FLD_CSEL_LSB +: FLD_CSEL_W];
        bus.cond_inv = rom_q[FLD_CINV_BIT];
    endtask

    // One sys_clk cycle; the ROM latches the address seen on a phase-clock edge
    task automatic cyc();
        logic             edge_b;
        logic             rst_b;
        logic [MC_AW-1:0] a_b;
        edge_b = clk && !clk_last;
        rst_b  = reset;
        a_b    = bus.a;
        @(posedge sys_clk);
        #1;
        clk_last  = rst_b ? 1'b1 : clk;
        last_edge = edge_b && !rst_b;
        if (edge_b) begin
            rom_q = rom[a_b];
            drive_rom();
        end
        ph  = (ph + 1) % 4;
        clk = (ph < 2) ? 1'b1 : 1'b0;
    endtask

    task automatic chk_a(input string tag, input logic [MC_AW-1:0] exp);
        nvec++;
        assert (bus.a === exp) else begin
            nerr++;
            $error("FAIL %s: a observed %0h expected %0h", tag, bus.a, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    // Advance to the next phase-clock edge, then one cycle so the step's new a is visible
    task automatic stepi();
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!last_edge && n < 8);
        nvec++;
        assert (last_edge) else begin
            nerr++;
            $error("FAIL edge_timeout: observed no edge expected edge within 8 cycles");
        end
        cyc();
    endtask

    task automatic start_pulse(input logic [MC_AW-1:0] sa);
        bus.start_addr = sa;
        bus.start      = 1'b1;
        cyc();
        bus.start      = 1'b0;
    endtask

    logic [MC_AW-1:0] loop_seq [8];

    initial begin
        nvec = 0;
        nerr = 0;
        ph = 0;
        clk = 1'b0;
        clk_last = 1'b0;
        last_edge = 1'b0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.start_addr = 6'd0;
        bus.cond = 4'b0000;
        for (int i = 0; i < 64; i++) rom[i] = {MW_W{1'b0}};
        rom_q = {MW_W{1'b0}};
        drive_rom();

        cyc(); cyc();
        chk_a("reset_a", 6'd0);
        chk_bit("reset_busy", bus.busy, 1'b0);
        chk_bit("reset_err", bus.err, 1'b0);
        reset = 1'b0;
        repeat (12) cyc();
        chk_a("idle_a", 6'd0);
        chk_bit("idle_busy", bus.busy, 1'b0);

        // Wrap-around increment from 62
        rom[2] = mw(SEQ_HALT, 6'd0, 2'd0, 1'b0);
        start_pulse(6'd62);
        chk_a("start_a", 6'd62);
        chk_bit("start_busy", bus.busy, 1'b1);
        stepi(); chk_a("inc_63", 6'd63);
        stepi(); chk_a("wrap_0", 6'd0);
        stepi(); chk_a("inc_1", 6'd1);
        stepi(); chk_a("inc_2", 6'd2);
        stepi(); chk_a("halt_2", 6'd2);
        chk_bit("halt2_busy", bus.busy, 1'b0);

        // JUMP then BRANCH on cond[2], with start ignored while running
        bus.cond  = 4'b0100;
        rom[5]    = mw(SEQ_JUMP, 6'h20, 2'd0, 1'b0);
        rom[6'h20] = mw(SEQ_BRANCH, 6'h30, 2'd2, 1'b0);
        rom[6'h30] = mw(SEQ_HALT, 6'd0, 2'd0, 1'b0);
        start_pulse(6'd5);
        chk_a("jmp_start", 6'd5);
        stepi(); chk_a("jump_20", 6'h20);
        start_pulse(6'h3F);
        chk_a("start_in_run", 6'h20);
        stepi(); chk_a("branch_taken", 6'h30);
        stepi(); chk_bit("branch_halt_busy", bus.busy, 1'b0);
        rom[6'h20] = mw(SEQ_BRANCH, 6'h30, 2'd2, 1'b1);
        rom[6'h21] = mw(SEQ_HALT, 6'd0, 2'd0, 1'b0);
        start_pulse(6'd5);
        stepi(); chk_a("jump_20_b", 6'h20);
        stepi(); chk_a("branch_inv", 6'h21);
        stepi(); chk_bit("inv_halt_busy", bus.busy, 1'b0);

        // Single CALL/RET
        rom[3]     = mw(SEQ_CALL, 6'h10, 2'd0, 1'b0);
        rom[6'h10] = mw(SEQ_RET, 6'd0, 2'd0, 1'b0);
        rom[4]     = mw(SEQ_HALT, 6'd0, 2'd0, 1'b0);
        start_pulse(6'd3);
        stepi(); chk_a("call_10", 6'h10);
        stepi(); chk_a("ret_4", 6'd4);
        stepi(); chk_bit("call_err", bus.err, 1'b0);

        // Five nested CALLs overflow a 4-deep stack, five RETs underflow it
        rom[6'h08] = mw(SEQ_CALL, 6'h18, 2'd0, 1'b0);
        rom[6'h18] = mw(SEQ_CALL, 6'h28, 2'd0, 1'b0);
        rom[6'h28] = mw(SEQ_CALL, 6'h38, 2'd0, 1'b0);
        rom[6'h38] = mw(SEQ_CALL, 6'h3C, 2'd0, 1'b0);
        rom[6'h3C] = mw(SEQ_CALL, 6'h3E, 2'd0, 1'b0);
        rom[6'h3E] = mw(SEQ_RET, 6'd0, 2'd0, 1'b0);
        rom[6'h3D] = mw(SEQ_RET, 6'd0, 2'd0, 1'b0);
        rom[6'h39] = mw(SEQ_RET, 6'd0, 2'd0, 1'b0);
        rom[6'h29] = mw(SEQ_RET, 6'd0, 2'd0, 1'b0);
        rom[6'h19] = mw(SEQ_RET, 6'd0, 2'd0, 1'b0);
        start_pulse(6'h08);
        stepi(); chk_a("nest_18", 6'h18);
        stepi(); chk_a("nest_28", 6'h28);
        stepi(); chk_a("nest_38", 6'h38);
        stepi(); chk_a("nest_3c", 6'h3C);
        chk_bit("nest_err_pre", bus.err, 1'b0);
        stepi(); chk_a("nest_3e", 6'h3E);
        chk_bit("nest_err_ovf", bus.err, 1'b1);
        stepi(); chk_a("ret_3d", 6'h3D);
        stepi(); chk_a("ret_39", 6'h39);
        stepi(); chk_a("ret_29", 6'h29);
        stepi(); chk_a("ret_19", 6'h19);
        stepi(); chk_a("ret_empty", 6'd0);
        chk_bit("ret_empty_busy", bus.busy, 1'b0);
        chk_bit("ret_empty_err", bus.err, 1'b1);

        // LDCNT 2 / LOOP runs the body three times
        rom[8]  = mw(SEQ_LDCNT, 6'd2, 2'd0, 1'b0);
        rom[9]  = mw(SEQ_NEXT, 6'd0, 2'd0, 1'b0);
        rom[10] = mw(SEQ_LOOP, 6'd9, 2'd0, 1'b0);
        rom[11] = mw(SEQ_HALT, 6'd0, 2'd0, 1'b0);
        loop_seq = '{6'd9, 6'd10, 6'd9, 6'd10, 6'd9, 6'd10, 6'd11, 6'd11};
        start_pulse(6'd8);
        chk_bit("start_clears_err", bus.err, 1'b0);
        for (int i = 0; i < 8; i++) begin
            stepi();
            chk_a($sformatf("loop_%0d", i), loop_seq[i]);
        end
        chk_bit("loop_busy", bus.busy, 1'b0);

        // HALT holds the address
        rom[6'h14] = mw(SEQ_NEXT, 6'd0, 2'd0, 1'b0);
        rom[6'h15] = mw(SEQ_HALT, 6'd0, 2'd0, 1'b0);
        start_pulse(6'h14);
        stepi(); chk_a("pre_halt", 6'h15);
        stepi(); chk_bit("halt_busy", bus.busy, 1'b0);
        repeat (8) cyc();
        chk_a("halt_hold", 6'h15);

        // Start on an edge cycle: the stale word latched for 0x15 must not execute
        rom[6'h15] = mw(SEQ_JUMP, 6'h3F, 2'd0, 1'b0);
        rom[6'h28] = mw(SEQ_NEXT, 6'd0, 2'd0, 1'b0);
        rom[6'h29] = mw(SEQ_HALT, 6'd0, 2'd0, 1'b0);
        for (int n = 0; n < 8 && !(clk && !clk_last); n++) cyc();
        nvec++;
        assert (clk && !clk_last) else begin
            nerr++;
            $error("FAIL edge_align: observed no edge expected edge within 8 cycles");
        end
        start_pulse(6'h28);
        chk_a("edge_start", 6'h28);
        stepi(); chk_a("edge_start_next", 6'h29);
        stepi(); chk_bit("edge_start_busy", bus.busy, 1'b0);

        // Reset mid-run with cnt = 5 and two return addresses stacked
        rom[1] = mw(SEQ_LDCNT, 6'd5, 2'd0, 1'b0);
        rom[2] = mw(SEQ_CALL, 6'd4, 2'd0, 1'b0);
        rom[4] = mw(SEQ_CALL, 6'd6, 2'd0, 1'b0);
        rom[6] = mw(SEQ_NEXT, 6'd0, 2'd0, 1'b0);
        rom[7] = mw(SEQ_NEXT, 6'd0, 2'd0, 1'b0);
        start_pulse(6'd1);
        stepi(); chk_a("pre_rst_2", 6'd2);
        stepi(); chk_a("pre_rst_4", 6'd4);
        stepi(); chk_a("pre_rst_6", 6'd6);
        reset = 1'b1;
        cyc();
        chk_a("midrst_a", 6'd0);
        chk_bit("midrst_busy", bus.busy, 1'b0);
        chk_bit("midrst_err", bus.err, 1'b0);
        reset = 1'b0;
        rom[6'h0A] = mw(SEQ_LOOP, 6'h0C, 2'd0, 1'b0);
        rom[6'h0B] = mw(SEQ_RET, 6'd0, 2'd0, 1'b0);
        rom[6'h0C] = mw(SEQ_HALT, 6'd0, 2'd0, 1'b0);
        start_pulse(6'h0A);
        stepi(); chk_a("post_rst_cnt0", 6'h0B);
        stepi(); chk_a("post_rst_sp0", 6'd0);
        chk_bit("post_rst_err", bus.err, 1'b1);
        chk_bit("post_rst_busy", bus.busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
